// File: rtl/axi_lite_master.sv
// axi_lite_master
// Single-outstanding AXI4-Lite initiator. A command accepted on the
// cmd_* port becomes one AXI4-Lite write (AW + W, then B) or one read
// (AR, then R). The response is returned on the rsp_* port and held there
// until it is consumed.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_write             1 = write, 0 = read
//   cmd_addr/wdata/wstrb  command payload (wdata/wstrb ignored for reads)
//   rsp_valid/rsp_ready   response handshake
//   rsp_write             echo of cmd_write
//   rsp_rdata/rsp_resp    RDATA (0 for writes) and BRESP/RRESP as received
//   AW*, W*, B*, AR*, R*  AXI4-Lite initiator channels
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// WRITE  | AWVALID/WVALID outstanding, each drops after its handshake
// WRESP  | BREADY high, waiting for BVALID
// READ   | ARVALID high, waiting for ARREADY
// RDATA  | RREADY high, waiting for RVALID
// RESP   | rsp_valid high with a stable payload, waiting for rsp_ready
module axi_lite_master #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic aw_done_q, w_done_q;
    logic aw_fin, w_fin;
    logic accept;
    logic cmd_ready_d, awvalid_d, wvalid_d, bready_d;
    logic arvalid_d, rready_d, rsp_valid_d;

    assign accept = cmd_valid && cmd_ready;

    // A channel counts as finished if it handshook earlier in this write or
    // is handshaking right now; gating on WRITE keeps a stale flag from the
    // previous write out of the IDLE->WRITE transition.
    assign aw_fin = (state_q == S_WRITE) && (aw_done_q || (AWVALID && AWREADY));
    assign w_fin  = (state_q == S_WRITE) && (w_done_q  || (WVALID  && WREADY));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = cmd_write ? S_WRITE : S_READ;
            S_WRITE: if (aw_fin && w_fin) state_d = S_WRESP;
            S_WRESP: if (BVALID) state_d = S_RESP;
            S_READ:  if (ARVALID && ARREADY) state_d = S_RDATA;
            S_RDATA: if (RVALID) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state and registered, so
    // every VALID/READY is a flop output and never follows the peer's
    // READY/VALID combinationally.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        awvalid_d   = (state_d == S_WRITE) && !aw_fin;
        wvalid_d    = (state_d == S_WRITE) && !w_fin;
        bready_d    = (state_d == S_WRESP);
        arvalid_d   = (state_d == S_READ);
        rready_d    = (state_d == S_RDATA);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmd_ready <= 1'b1;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            AWADDR    <= '0;
            WDATA     <= '0;
            WSTRB     <= '0;
            ARADDR    <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            cmd_ready <= cmd_ready_d;
            AWVALID   <= awvalid_d;
            WVALID    <= wvalid_d;
            BREADY    <= bready_d;
            ARVALID   <= arvalid_d;
            RREADY    <= rready_d;
            rsp_valid <= rsp_valid_d;

            if (accept) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                rsp_write <= cmd_write;
                if (cmd_write) begin
                    AWADDR <= cmd_addr;
                    WDATA  <= cmd_wdata;
                    WSTRB  <= cmd_wstrb;
                end else begin
                    ARADDR <= cmd_addr;
                end
            end else if (state_q == S_WRITE) begin
                aw_done_q <= aw_fin;
                w_done_q  <= w_fin;
            end

            if ((state_q == S_WRESP) && BVALID) begin
                rsp_resp  <= BRESP;
                rsp_rdata <= '0;
            end
            if ((state_q == S_RDATA) && RVALID) begin
                rsp_resp  <= RRESP;
                rsp_rdata <= RDATA;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
module tb_axi_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // responder configuration, changed by the stimulus only while idle
    int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0;
    int          cfg_ar_delay = 0, cfg_r_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    bit          cfg_rdata_en = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    // ---------------- responder (slave side) ----------------
    logic [31:0] s_mem [256];
    initial begin : responder
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s;
        bit aw_got, w_got, ar_got, written;
        int aw_wait, w_wait, b_wait, ar_wait, r_wait;
        logic [31:0] aw_a, w_d, ar_a;
        logic [3:0]  w_s;
        for (int i = 0; i < 256; i++) s_mem[i] = 32'h0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_got = 0; w_got = 0; ar_got = 0; written = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_a = 0; w_d = 0; w_s = 0; ar_a = 0;
        forever begin
            @(negedge ACLK);
            rst_s = ARESET;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            if (aw_hs) aw_a = AWADDR;
            if (w_hs) begin w_d = WDATA; w_s = WSTRB; end
            if (ar_hs) ar_a = ARADDR;
            @(posedge ACLK); #1;
            if (rst_s) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_got = 0; w_got = 0; ar_got = 0; written = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                continue;
            end
            if (aw_hs) aw_got = 1;
            if (w_hs)  w_got = 1;
            if (ar_hs) ar_got = 1;
            if (b_hs) begin
                BVALID = 0; aw_got = 0; w_got = 0; written = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0;
            end
            if (r_hs) begin
                RVALID = 0; ar_got = 0; ar_wait = 0; r_wait = 0;
            end
            AWREADY = 0;
            if (AWVALID && !aw_got) begin AWREADY = (aw_wait >= cfg_aw_delay); aw_wait++; end
            WREADY = 0;
            if (WVALID && !w_got) begin WREADY = (w_wait >= cfg_w_delay); w_wait++; end
            ARREADY = 0;
            if (ARVALID && !ar_got) begin ARREADY = (ar_wait >= cfg_ar_delay); ar_wait++; end
            if (aw_got && w_got && !BVALID) begin
                if (!written) begin
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) s_mem[aw_a[7:0]][8*b +: 8] = w_d[8*b +: 8];
                    written = 1;
                end
                if (b_wait >= cfg_b_delay) begin BVALID = 1; BRESP = cfg_bresp; end
                else b_wait++;
            end
            if (ar_got && !RVALID) begin
                if (r_wait >= cfg_r_delay) begin
                    RVALID = 1;
                    RDATA  = cfg_rdata_en ? cfg_rdata : s_mem[ar_a[7:0]];
                    RRESP  = cfg_rresp;
                end else r_wait++;
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    logic [31:0] m_mem [256];
    bit          armed = 0, rst_prev = 0;
    bit          m_busy = 0, m_wr = 0;
    bit          m_aw_done, m_w_done, m_b_done, m_ar_done, m_r_done;
    logic [31:0] m_addr, m_wdata, m_exp_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_exp_resp;
    int          m_aw_cnt, m_w_cnt, m_ar_cnt, m_awv_cyc, m_wv_cyc, m_arv_cyc;

    initial begin : compare
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        {m_aw_done, m_w_done, m_b_done, m_ar_done, m_r_done} = '0;
        m_addr = 0; m_wdata = 0; m_wstrb = 0; m_exp_rdata = 0; m_exp_resp = 0;
        m_aw_cnt = 0; m_w_cnt = 0; m_ar_cnt = 0; m_awv_cyc = 0; m_wv_cyc = 0; m_arv_cyc = 0;
        forever begin
            @(negedge ACLK);
            if (armed) begin
                if (rst_prev) begin
                    chk("rst_awaddr", AWADDR, 0);
                    chk("rst_wdata", WDATA, 0);
                    chk("rst_wstrb", WSTRB, 0);
                    chk("rst_araddr", ARADDR, 0);
                    chk("rst_rsp_rdata", rsp_rdata, 0);
                    chk("rst_rsp_resp", rsp_resp, 0);
                    chk("rst_rsp_write", rsp_write, 0);
                end
                chk("cmd_ready", cmd_ready, !m_busy);
                chk("awvalid", AWVALID, m_busy && m_wr && !m_aw_done);
                chk("wvalid", WVALID, m_busy && m_wr && !m_w_done);
                chk("bready", BREADY, m_busy && m_wr && m_aw_done && m_w_done && !m_b_done);
                chk("arvalid", ARVALID, m_busy && !m_wr && !m_ar_done);
                chk("rready", RREADY, m_busy && !m_wr && m_ar_done && !m_r_done);
                chk("rsp_valid", rsp_valid, m_busy && (m_wr ? m_b_done : m_r_done));
                if (AWVALID) chk("awaddr", AWADDR, m_addr);
                if (WVALID) begin
                    chk("wdata", WDATA, m_wdata);
                    chk("wstrb", WSTRB, m_wstrb);
                end
                if (ARVALID) chk("araddr", ARADDR, m_addr);
                if (rsp_valid) begin
                    chk("rsp_write", rsp_write, m_wr);
                    chk("rsp_rdata", rsp_rdata, m_exp_rdata);
                    chk("rsp_resp", rsp_resp, m_exp_resp);
                end
            end
            if (ARESET) begin
                armed = 1; rst_prev = 1; m_busy = 0;
                {m_aw_done, m_w_done, m_b_done, m_ar_done, m_r_done} = '0;
            end else begin
                rst_prev = 0;
                if (cmd_valid && cmd_ready) begin
                    m_busy = 1; m_wr = cmd_write; m_addr = cmd_addr;
                    m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
                    {m_aw_done, m_w_done, m_b_done, m_ar_done, m_r_done} = '0;
                    m_aw_cnt = 0; m_w_cnt = 0; m_ar_cnt = 0;
                    m_awv_cyc = 0; m_wv_cyc = 0; m_arv_cyc = 0;
                    if (cmd_write) begin
                        for (int b = 0; b < 4; b++)
                            if (cmd_wstrb[b]) m_mem[cmd_addr[7:0]][8*b +: 8] = cmd_wdata[8*b +: 8];
                        m_exp_rdata = 0;
                        m_exp_resp  = cfg_bresp;
                    end else begin
                        m_exp_rdata = cfg_rdata_en ? cfg_rdata : m_mem[cmd_addr[7:0]];
                        m_exp_resp  = cfg_rresp;
                    end
                end
                if (AWVALID) m_awv_cyc++;
                if (WVALID)  m_wv_cyc++;
                if (ARVALID) m_arv_cyc++;
                if (AWVALID && AWREADY) begin m_aw_done = 1; m_aw_cnt++; end
                if (WVALID && WREADY)   begin m_w_done = 1;  m_w_cnt++;  end
                if (ARVALID && ARREADY) begin m_ar_done = 1; m_ar_cnt++; end
                if (BVALID && BREADY) m_b_done = 1;
                if (RVALID && RREADY) m_r_done = 1;
                if (rsp_valid && rsp_ready) m_busy = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold,
                           output int lat, output int vcyc, output logic post_rdy,
                           output logic r_wr, output logic [31:0] r_data, output logic [1:0] r_resp);
        bit ok;
        lat = -1; vcyc = 0; post_rdy = 0; r_wr = 0; r_data = 0; r_resp = 0;
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        rsp_ready = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            if (cmd_ready) ok = 1;
        end
        chk("accept_in_time", ok, 1);
        @(posedge ACLK); #1;
        cmd_valid = 0;
        if (!ok) return;
        ok = 0; lat = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            lat++;
            if (rsp_valid) ok = 1;
        end
        chk("rsp_in_time", ok, 1);
        if (!ok) return;
        vcyc = cmd_ready ? 0 : 1;
        for (int i = 1; i < hold; i++) begin
            @(negedge ACLK);
            if (rsp_valid && !cmd_ready) vcyc++;
        end
        @(posedge ACLK); #1;
        rsp_ready = 1;
        @(negedge ACLK);
        r_wr = rsp_write; r_data = rsp_rdata; r_resp = rsp_resp;
        @(posedge ACLK); #1;
        rsp_ready = 0;
        @(negedge ACLK);
        post_rdy = cmd_ready;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, vc;
        logic pr, rw;
        logic [31:0] rd;
        logic [1:0] rr;
        bit ok;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        @(negedge ACLK);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);

        // zero-wait write then read back
        run_cmd(1, 32'h5, 32'hDEADBEEF, 4'hF, 1, lat, vc, pr, rw, rd, rr);
        chk("wr_latency", lat, 3);
        chk("wr_rsp_write", rw, 1);
        chk("wr_rsp_rdata", rd, 0);
        chk("wr_rsp_resp", rr, 2'b00);
        chk("wr_aw_count", m_aw_cnt, 1);
        chk("wr_w_count", m_w_cnt, 1);
        chk("wr_idle_after", pr, 1);

        run_cmd(0, 32'h5, 32'h0, 4'h0, 1, lat, vc, pr, rw, rd, rr);
        chk("rd_latency", lat, 3);
        chk("rd_rsp_write", rw, 0);
        chk("rd_rsp_rdata", rd, 32'hDEADBEEF);
        chk("rd_rsp_resp", rr, 2'b00);
        chk("rd_ar_count", m_ar_cnt, 1);

        // AW accepted 3 cycles late, W immediately; partial-strobe write
        run_cmd(1, 32'h8, 32'h11223344, 4'hF, 1, lat, vc, pr, rw, rd, rr);
        cfg_aw_delay = 3;
        run_cmd(1, 32'h8, 32'hA5A5A5A5, 4'h1, 1, lat, vc, pr, rw, rd, rr);
        chk("awdly_latency", lat, 6);
        chk("awdly_awvalid_cycles", m_awv_cyc, 4);
        chk("awdly_wvalid_cycles", m_wv_cyc, 1);
        chk("awdly_w_count", m_w_cnt, 1);
        chk("awdly_aw_count", m_aw_cnt, 1);
        cfg_aw_delay = 0;
        run_cmd(0, 32'h8, 32'h0, 4'h0, 1, lat, vc, pr, rw, rd, rr);
        chk("strb_readback", rd, 32'h112233A5);

        // slow R with SLVERR and injected data
        cfg_r_delay = 4; cfg_rresp = 2'b10; cfg_rdata_en = 1; cfg_rdata = 32'h12345678;
        run_cmd(0, 32'h20, 32'h0, 4'h0, 1, lat, vc, pr, rw, rd, rr);
        chk("rerr_latency", lat, 7);
        chk("rerr_rsp_resp", rr, 2'b10);
        chk("rerr_rsp_rdata", rd, 32'h12345678);
        chk("rerr_ar_count", m_ar_cnt, 1);
        chk("rerr_arvalid_cycles", m_arv_cyc, 1);
        cfg_r_delay = 0; cfg_rresp = 2'b00; cfg_rdata_en = 0;

        // DECERR on a write
        cfg_bresp = 2'b11;
        run_cmd(1, 32'h30, 32'h55AA55AA, 4'hF, 1, lat, vc, pr, rw, rd, rr);
        chk("werr_rsp_resp", rr, 2'b11);
        chk("werr_rsp_rdata", rd, 0);
        cfg_bresp = 2'b00;

        // response consumer stalls for 5 cycles
        run_cmd(0, 32'h5, 32'h0, 4'h0, 5, lat, vc, pr, rw, rd, rr);
        chk("hold_valid_cycles", vc, 5);
        chk("hold_idle_after", pr, 1);
        chk("hold_rsp_rdata", rd, 32'hDEADBEEF);

        // reset while waiting for B
        cfg_b_delay = 6;
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        cmd_valid = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            if (BREADY) ok = 1;
        end
        chk("rst_reach_wresp", ok, 1);
        @(posedge ACLK); #1 ARESET = 1;
        @(posedge ACLK); #1 ARESET = 0;
        @(negedge ACLK);
        chk("midrst_bready", BREADY, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_awaddr", AWADDR, 0);
        cfg_b_delay = 0;
        run_cmd(1, 32'h40, 32'h0BADC0DE, 4'hF, 1, lat, vc, pr, rw, rd, rr);
        chk("postrst_wr_latency", lat, 3);
        run_cmd(0, 32'h40, 32'h0, 4'h0, 1, lat, vc, pr, rw, rd, rr);
        chk("postrst_rd_rdata", rd, 32'h0BADC0DE);

        repeat (3) @(negedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
